// File: rtl/flex_cnt_pkg.sv
// flex_cnt_pkg: shared types for the flex_down_counter block
package flex_cnt_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } cnt_state_t;

endpackage

// File: rtl/flex_down_counter.sv
// flex_down_counter: loadable down counter with optional auto-reload and a terminal-count pulse
module flex_down_counter
    import flex_cnt_pkg::*;
#(
    parameter int NUM_CNT_BITS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    load,
    input  logic [NUM_CNT_BITS-1:0] load_val,
    input  logic                    auto_reload,
    input  logic                    count_enable,
    output logic                    ready,
    output logic                    busy,
    output logic [NUM_CNT_BITS-1:0] count_out,
    output logic                    done_flag
);

    localparam logic [NUM_CNT_BITS-1:0] ONE = NUM_CNT_BITS'(1);

    cnt_state_t              state, state_n;
    logic [NUM_CNT_BITS-1:0] count_n, reload_val, reload_val_n;
    logic                    reload_mode, reload_mode_n, done_n;

    assign ready = (state != RUN);
    assign busy  = (state == RUN);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            count_out   <= '0;
            reload_val  <= '0;
            reload_mode <= 1'b0;
            done_flag   <= 1'b0;
        end else begin
            state       <= state_n;
            count_out   <= count_n;
            reload_val  <= reload_val_n;
            reload_mode <= reload_mode_n;
            done_flag   <= done_n;
        end
    end

    // done_n only rises on a terminal event, so done_flag is a single-cycle pulse
    always_comb begin
        state_n       = state;
        count_n       = count_out;
        reload_val_n  = reload_val;
        reload_mode_n = reload_mode;
        done_n        = 1'b0;
        if (clear) begin
            state_n       = IDLE;
            count_n       = '0;
            reload_val_n  = '0;
            reload_mode_n = 1'b0;
        end else if (load && ready) begin
            if (load_val == '0) begin
                state_n = DONE;
                count_n = '0;
                done_n  = 1'b1;
            end else begin
                state_n       = RUN;
                count_n       = load_val;
                reload_val_n  = load_val;
                reload_mode_n = auto_reload;
            end
        end else if (busy && count_enable) begin
            if (count_out > ONE) begin
                count_n = count_out - ONE;
            end else begin
                done_n  = 1'b1;
                count_n = reload_mode ? reload_val : '0;
                state_n = reload_mode ? RUN : DONE;
            end
        end
    end

endmodule

// File: tb/tb_flex_down_counter.sv
// tb_flex_down_counter: directed and random stimulus checked against a behavioural model
module tb_flex_down_counter;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst, clear, load, auto_reload, count_enable;
    logic [W-1:0] load_val;
    logic         ready, busy, done_flag;
    logic [W-1:0] count_out;

    int n_checks = 0;
    int n_fail   = 0;

    // model state: plain integers, "running" means a count is in progress
    int m_cnt, m_rel;
    bit m_run, m_auto, m_done;

    flex_down_counter #(.NUM_CNT_BITS(W)) dut (
        .clk(clk), .rst(rst), .clear(clear), .load(load), .load_val(load_val),
        .auto_reload(auto_reload), .count_enable(count_enable), .ready(ready),
        .busy(busy), .count_out(count_out), .done_flag(done_flag)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_update(input bit r, input bit c, input bit l, input int lv,
                                input bit ar, input bit en);
        if (r || c) begin
            m_cnt = 0; m_rel = 0; m_auto = 0; m_run = 0; m_done = 0;
        end else if (l && !m_run) begin
            m_done = (lv == 0);
            m_cnt  = lv;
            if (lv != 0) begin
                m_rel = lv; m_auto = ar; m_run = 1;
            end
        end else if (m_run && en) begin
            m_done = (m_cnt == 1);
            if (m_cnt > 1) m_cnt = m_cnt - 1;
            else if (m_auto) m_cnt = m_rel;
            else begin
                m_cnt = 0; m_run = 0;
            end
        end else begin
            m_done = 0;
        end
    endtask

    task automatic cycle(input bit r, input bit c, input bit l, input int lv,
                         input bit ar, input bit en);
        rst = r; clear = c; load = l; load_val = W'(lv); auto_reload = ar; count_enable = en;
        @(posedge clk);
        model_update(r, c, l, lv, ar, en);
        #1;
        check("count_out", int'(count_out), m_cnt);
        check("done_flag", int'(done_flag), int'(m_done));
        check("busy", int'(busy), int'(m_run));
        check("ready", int'(ready), int'(!m_run));
    endtask

    initial begin
        m_cnt = 0; m_rel = 0; m_run = 0; m_auto = 0; m_done = 0;
        repeat (2) cycle(1, 0, 0, 0, 0, 0);
        // three-count one-shot, ending in DONE
        cycle(0, 0, 1, 3, 0, 1);
        repeat (5) cycle(0, 0, 0, 0, 0, 1);
        check("one_shot_end", int'(count_out), 0);
        // auto-reload by two, then clear
        cycle(0, 0, 1, 2, 1, 1);
        repeat (6) cycle(0, 0, 0, 0, 0, 1);
        cycle(0, 1, 0, 0, 0, 1);
        // zero load goes straight to DONE
        cycle(0, 0, 1, 0, 0, 0);
        check("zero_load_pulse", int'(done_flag), 1);
        repeat (2) cycle(0, 0, 0, 0, 0, 1);
        // gated enable with an ignored load while busy
        cycle(0, 0, 1, 5, 0, 0);
        cycle(0, 0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 0, 0);
        cycle(0, 0, 1, 9, 1, 0);
        cycle(0, 0, 0, 0, 0, 1);
        check("gated_count", int'(count_out), 3);
        // clear beats a simultaneous load
        cycle(0, 0, 1, 3, 0, 0);
        cycle(0, 0, 0, 0, 0, 1);
        cycle(0, 1, 1, 7, 0, 1);
        check("clear_vs_load", int'(busy), 0);
        // full-scale load, no wrap afterwards
        cycle(0, 0, 1, 15, 0, 0);
        repeat (18) cycle(0, 0, 0, 0, 0, 1);
        check("no_wrap", int'(count_out), 0);
        // reset mid-run abandons the count
        cycle(0, 0, 1, 4, 1, 1);
        cycle(0, 0, 0, 0, 0, 1);
        cycle(1, 0, 1, 6, 0, 1);
        cycle(0, 0, 0, 0, 0, 1);
        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            int sel;
            int lv;
            sel = $urandom_range(0, 9);
            lv  = (sel == 0) ? 0 : (sel == 1) ? 15 : $urandom_range(1, 6);
            cycle(($urandom_range(0, 149) == 0), ($urandom_range(0, 39) == 0),
                  ($urandom_range(0, 5) == 0), lv, $urandom_range(0, 1),
                  ($urandom_range(0, 9) < 7));
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
